// File: rtl/tb_hwpe_stream_source_if.sv
// HWPE stream handshake bundle: data/strb/valid travel source->sink, ready travels sink->source.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;
   logic                  valid;
   logic                  ready;

   modport source (output data, output strb, output valid, input ready);
   modport sink   (input data, input strb, input valid, output ready);
endinterface

// File: rtl/tb_hwpe_stream_source.sv
// Stream transmitter: sends a programmed burst of beats with LFSR-driven valid stalls,
// reproducible from a seed.
module tb_hwpe_stream_source #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STALL_X256 = 0,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [CNT_WIDTH-1:0] nb_beats_i,
   input  logic                 mode_i,
   input  logic [31:0]          seed_i,
   hwpe_stream_intf_stream.source data_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_WIDTH-1:0] beat_cnt_o
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned REP        = (DATA_WIDTH + 31) / 32;
   localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   function automatic logic [31:0] lfsr_next(input logic [31:0] x);
      return (x >> 1) ^ (x[0] ? LFSR_TAPS : 32'h0);
   endfunction

   // Word for a beat: its index (mode 0) or the LFSR state replicated/truncated (mode 1).
   function automatic logic [DATA_WIDTH-1:0] make_word(input logic                 mode,
                                                       input logic [CNT_WIDTH-1:0] idx,
                                                       input logic [31:0]          lfsr);
      logic [REP*32-1:0] rep;
      rep = {REP{lfsr}};
      return mode ? rep[DATA_WIDTH-1:0] : DATA_WIDTH'(idx);
   endfunction

   function automatic logic stall_hit(input logic [31:0] lfsr);
      return {1'b0, lfsr[7:0]} < 9'(STALL_X256);
   endfunction

   state_e                state_q, state_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [STRB_WIDTH-1:0] strb_q, strb_d;
   logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0]  nb_beats_q, nb_beats_d;
   logic                  mode_q, mode_d;
   logic [31:0]           stall_lfsr_q, stall_lfsr_d;
   logic [31:0]           data_lfsr_q, data_lfsr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [31:0]           seed_sel;
   logic                  hs;

   assign seed_sel = (seed_i == 32'h0) ? 32'h1 : seed_i;
   assign hs       = valid_q & data_o.ready;

   // Next-state and output logic; data_lfsr_q always holds the state for beat index beat_cnt_q.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      data_d       = data_q;
      beat_cnt_d   = beat_cnt_q;
      nb_beats_d   = nb_beats_q;
      mode_d       = mode_q;
      stall_lfsr_d = stall_lfsr_q;
      data_lfsr_d  = data_lfsr_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               nb_beats_d   = nb_beats_i;
               mode_d       = mode_i;
               beat_cnt_d   = '0;
               data_lfsr_d  = seed_sel;
               stall_lfsr_d = seed_sel;
               if (nb_beats_i == '0) begin
                  state_d = DONE;
               end else begin
                  state_d      = RUN;
                  stall_lfsr_d = lfsr_next(seed_sel);
                  valid_d      = !stall_hit(stall_lfsr_d);
                  if (valid_d) data_d = make_word(mode_i, '0, seed_sel);
               end
            end
         end
         RUN: begin
            if (hs) begin
               beat_cnt_d  = beat_cnt_q + CNT_WIDTH'(1);
               data_lfsr_d = lfsr_next(data_lfsr_q);
            end
            if (hs && (beat_cnt_d == nb_beats_q)) begin
               valid_d = 1'b0;
               state_d = DONE;
            end else if (!valid_q || hs) begin
               stall_lfsr_d = lfsr_next(stall_lfsr_q);
               valid_d      = !stall_hit(stall_lfsr_d);
               if (valid_d) data_d = make_word(mode_q, beat_cnt_d, data_lfsr_d);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Clear overrides everything, including a handshake in the same cycle.
      if (clear_i) begin
         state_d    = IDLE;
         valid_d    = 1'b0;
         beat_cnt_d = '0;
      end

      strb_d = valid_d ? '1 : '0;
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         valid_q      <= 1'b0;
         data_q       <= '0;
         strb_q       <= '0;
         beat_cnt_q   <= '0;
         nb_beats_q   <= '0;
         mode_q       <= 1'b0;
         stall_lfsr_q <= 32'h1;
         data_lfsr_q  <= 32'h1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         strb_q       <= strb_d;
         beat_cnt_q   <= beat_cnt_d;
         nb_beats_q   <= nb_beats_d;
         mode_q       <= mode_d;
         stall_lfsr_q <= stall_lfsr_d;
         data_lfsr_q  <= data_lfsr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign data_o.valid = valid_q;
   assign data_o.data  = data_q;
   assign data_o.strb  = strb_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign beat_cnt_o   = beat_cnt_q;
endmodule

// File: tb/tb_tb_hwpe_stream_source.sv
// Scoreboard bench for tb_hwpe_stream_source: one stall-free instance and one 50% stall instance.
module tb_tb_hwpe_stream_source;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          clear0, start0, mode0, busy0, done0;
   logic [CW-1:0] nb0, cnt0;
   logic [31:0]   seed0;
   logic          clear1, start1, mode1, busy1, done1;
   logic [CW-1:0] nb1, cnt1;
   logic [31:0]   seed1;

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) s0 ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) s1 ();

   tb_hwpe_stream_source #(.DATA_WIDTH(DW), .STALL_X256(0), .CNT_WIDTH(CW)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear0), .start_i(start0), .nb_beats_i(nb0),
      .mode_i(mode0), .seed_i(seed0), .data_o(s0), .busy_o(busy0), .done_o(done0),
      .beat_cnt_o(cnt0));

   tb_hwpe_stream_source #(.DATA_WIDTH(DW), .STALL_X256(128), .CNT_WIDTH(CW)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear1), .start_i(start1), .nb_beats_i(nb1),
      .mode_i(mode1), .seed_i(seed1), .data_o(s1), .busy_o(busy1), .done_o(done1),
      .beat_cnt_o(cnt1));

   int n_cmp = 0;
   int n_err = 0;
   int hs1_cnt = 0;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: pop the expected word on every handshake and check valid/data stability.
   logic          p0_valid = 1'b0, p0_ready = 1'b0, p0_clear = 1'b0;
   logic [DW-1:0] p0_data = '0;
   always @(negedge clk) begin : mon0
      logic [DW-1:0] e;
      if (rst_n) begin
         if (p0_valid && !p0_ready && !p0_clear) begin
            chk("s0_valid_hold", 64'(s0.valid), 64'(1));
            chk("s0_data_hold", 64'(s0.data), 64'(p0_data));
         end
         if (s0.valid && s0.ready) begin
            if (q0.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL s0_extra_beat: got %0h expected no beat", s0.data);
            end else begin
               e = q0.pop_front();
               chk("s0_data", 64'(s0.data), 64'(e));
               chk("s0_strb", 64'(s0.strb), 64'(4'hF));
            end
         end
      end
      p0_valid = s0.valid & rst_n;
      p0_ready = s0.ready;
      p0_clear = clear0;
      p0_data  = s0.data;
   end

   always @(negedge clk) begin : mon1
      logic [DW-1:0] e;
      if (rst_n && s1.valid && s1.ready) begin
         hs1_cnt++;
         if (q1.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL s1_extra_beat: got %0h expected no beat", s1.data);
         end else begin
            e = q1.pop_front();
            chk("s1_data", 64'(s1.data), 64'(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_dut(input int which, input int nb, input logic mode, input logic [31:0] seed);
      if (which == 0) begin
         start0 = 1'b1; nb0 = CW'(nb); mode0 = mode; seed0 = seed;
         tick();
         start0 = 1'b0;
      end else begin
         start1 = 1'b1; nb1 = CW'(nb); mode1 = mode; seed1 = seed;
         tick();
         start1 = 1'b0;
      end
   endtask

   task automatic wait_done0(input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = done0;
      end
      chk("done0_seen", 64'(seen), 64'(1));
   endtask

   logic wave_a[$];
   logic wave_b[$];

   initial begin
      rst_n = 1'b0;
      {clear0, start0, mode0, clear1, start1, mode1} = '0;
      nb0 = '0; nb1 = '0; seed0 = '0; seed1 = '0;
      s0.ready = 1'b0; s1.ready = 1'b0;
      @(negedge clk); @(negedge clk);
      chk("rst_valid", 64'(s0.valid), 64'(0));
      chk("rst_data", 64'(s0.data), 64'(0));
      chk("rst_strb", 64'(s0.strb), 64'(0));
      chk("rst_busy", 64'(busy0), 64'(0));
      chk("rst_done", 64'(done0), 64'(0));
      chk("rst_cnt", 64'(cnt0), 64'(0));
      chk("rst_valid1", 64'(s1.valid), 64'(0));
      tick();
      rst_n = 1'b1;
      tick();

      // Stall-free 4-beat incrementing burst with ready tied high.
      s0.ready = 1'b1;
      for (int i = 0; i < 4; i++) q0.push_back(DW'(i));
      start_dut(0, 4, 1'b0, 32'h1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_valid", 64'(s0.valid), 64'(1));
         chk("t1_busy", 64'(busy0), 64'(1));
         chk("t1_no_done", 64'(done0), 64'(0));
      end
      @(negedge clk);
      chk("t1_done", 64'(done0), 64'(1));
      chk("t1_valid_low", 64'(s0.valid), 64'(0));
      chk("t1_cnt", 64'(cnt0), 64'(4));
      @(negedge clk);
      chk("t1_done_pulse", 64'(done0), 64'(0));
      chk("t1_cnt_hold", 64'(cnt0), 64'(4));
      tick();

      // LFSR pattern, seed 1, with ready withheld for four cycles after the first beat.
      q0.push_back(32'h0000_0001);
      q0.push_back(32'h8020_0003);
      q0.push_back(32'hC030_0002);
      start_dut(0, 3, 1'b1, 32'h1);
      tick();
      s0.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_valid", 64'(s0.valid), 64'(1));
         chk("t2_data", 64'(s0.data), 64'(32'h8020_0003));
         chk("t2_cnt", 64'(cnt0), 64'(1));
         tick();
      end
      s0.ready = 1'b1;
      wait_done0(10);
      chk("t2_cnt_end", 64'(cnt0), 64'(3));
      tick();

      // Zero-beat burst completes immediately.
      start_dut(0, 0, 1'b0, 32'h1);
      @(negedge clk);
      chk("t4_done", 64'(done0), 64'(1));
      chk("t4_valid", 64'(s0.valid), 64'(0));
      chk("t4_cnt", 64'(cnt0), 64'(0));
      chk("t4_busy", 64'(busy0), 64'(0));
      @(negedge clk);
      chk("t4_done_pulse", 64'(done0), 64'(0));
      tick();

      // Clear after two of eight beats, then restart.
      q0.push_back(32'd0);
      q0.push_back(32'd1);
      start_dut(0, 8, 1'b0, 32'h1);
      tick();
      tick();
      s0.ready = 1'b0;
      clear0 = 1'b1;
      @(negedge clk);
      chk("t5_cnt_pre", 64'(cnt0), 64'(2));
      tick();
      clear0 = 1'b0;
      @(negedge clk);
      chk("t5_valid", 64'(s0.valid), 64'(0));
      chk("t5_cnt", 64'(cnt0), 64'(0));
      chk("t5_busy", 64'(busy0), 64'(0));
      for (int i = 0; i < 3; i++) begin
         chk("t5_no_done", 64'(done0), 64'(0));
         @(negedge clk);
      end
      tick();
      s0.ready = 1'b1;
      q0.push_back(32'd0);
      q0.push_back(32'd1);
      start_dut(0, 2, 1'b0, 32'h1);
      wait_done0(10);
      chk("t5_cnt_restart", 64'(cnt0), 64'(2));
      tick();

      // 50% stall instance: two identical-seed runs must give identical valid waveforms.
      s1.ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         logic seen;
         seen = 1'b0;
         hs1_cnt = 0;
         for (int i = 0; i < 100; i++) q1.push_back(DW'(i));
         start_dut(1, 100, 1'b0, 32'h0000_1234);
         for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (r == 0) wave_a.push_back(s1.valid);
            else        wave_b.push_back(s1.valid);
            seen = done1;
         end
         chk("t3_done_seen", 64'(seen), 64'(1));
         chk("t3_handshakes", 64'(hs1_cnt), 64'(100));
         chk("t3_cnt", 64'(cnt1), 64'(100));
         tick();
      end
      begin
         int diff, ones;
         diff = 0; ones = 0;
         chk("t3_wave_len", 64'(wave_b.size()), 64'(wave_a.size()));
         foreach (wave_a[i]) begin
            if (wave_a[i]) ones++;
            if (i < wave_b.size() && wave_a[i] !== wave_b[i]) diff++;
         end
         chk("t3_wave_diff", 64'(diff), 64'(0));
         chk("t3_valid_cycles", 64'(ones), 64'(100));
         chk("t3_stalls_seen", 64'(wave_a.size() > 101), 64'(1));
      end

      // Asynchronous reset while valid is high and ready is low.
      s0.ready = 1'b1;
      q0.push_back(32'd0);
      q0.push_back(32'd1);
      start_dut(0, 5, 1'b0, 32'h1);
      tick();
      tick();
      s0.ready = 1'b0;
      @(negedge clk);
      chk("t6_valid_pre", 64'(s0.valid), 64'(1));
      chk("t6_cnt_pre", 64'(cnt0), 64'(2));
      #2 rst_n = 1'b0;
      #1;
      chk("t6_valid", 64'(s0.valid), 64'(0));
      chk("t6_busy", 64'(busy0), 64'(0));
      chk("t6_cnt", 64'(cnt0), 64'(0));
      chk("t6_strb", 64'(s0.strb), 64'(0));
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      tick();
      tick();

      chk("q0_empty", 64'(q0.size()), 64'(0));
      chk("q1_empty", 64'(q1.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
